// File: rtl/vardelayline.sv
// Variable-latency delay line: MAX_LATENCY physical stages with a runtime-selectable tap,
// discard on flush or latency change, fill tracking and a sticky out-of-range latency flag.
module vardelayline #(
  parameter int WIDTH       = 8,
  parameter int MAX_LATENCY = 16,
  localparam int LW         = $clog2(MAX_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkena,
  input  logic [LW-1:0]    cfg_latency,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  input  logic             data_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [LW-1:0]    cur_latency,
  output logic             primed,
  output logic             lat_err
);

  localparam logic [LW-1:0] MAXL = LW'(MAX_LATENCY);

  logic [WIDTH-1:0]       r_data [MAX_LATENCY];
  logic [MAX_LATENCY-1:0] r_vld;
  logic [LW-1:0]          r_cur_lat;
  logic [LW-1:0]          r_fill;
  logic                   r_lat_err;
  logic [LW-1:0]          w_clamped;
  logic                   w_lat_chg;
  logic                   w_discard;

  always_comb begin
    w_clamped = (cfg_latency > MAXL) ? MAXL : cfg_latency;
    // An out-of-range request never equals the clamped value, so it re-discards every enabled edge.
    w_lat_chg = (cfg_latency != r_cur_lat);
    w_discard = flush | w_lat_chg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < MAX_LATENCY; k++) r_data[k] <= '0;
      r_vld     <= '0;
      r_fill    <= '0;
      r_lat_err <= 1'b0;
      r_cur_lat <= w_clamped;
    end else if (clkena) begin
      // Data bits always shift; only the valid bits and fill are subject to discard.
      r_data[0] <= data;
      for (int unsigned k = 1; k < MAX_LATENCY; k++) r_data[k] <= r_data[k-1];
      if (w_discard) begin
        r_vld  <= '0;
        r_fill <= '0;
      end else begin
        r_vld[0] <= data_valid;
        for (int unsigned k = 1; k < MAX_LATENCY; k++) r_vld[k] <= r_vld[k-1];
        if (r_fill != MAXL) r_fill <= r_fill + LW'(1);
      end
      if (w_lat_chg) begin
        r_cur_lat <= w_clamped;
        if (cfg_latency > MAXL) r_lat_err <= 1'b1;
      end
    end
  end

  always_comb begin
    q       = '0;
    q_valid = 1'b0;
    if (r_cur_lat == '0) begin
      q       = data;
      q_valid = data_valid;
    end else begin
      for (int unsigned k = 0; k < MAX_LATENCY; k++) begin
        if (r_cur_lat == LW'(k + 1)) begin
          q       = r_data[k];
          q_valid = r_vld[k];
        end
      end
    end
  end

  assign cur_latency = r_cur_lat;
  assign primed      = (r_cur_lat == '0) || (r_fill >= r_cur_lat);
  assign lat_err     = r_lat_err;

endmodule

// File: tb/tb_vardelayline.sv
// Bench for vardelayline: directed streams with literal expectations plus a per-cycle
// comparison against a sample-history model of the delay line.
module tb_vardelayline;

  localparam int W  = 8;
  localparam int M  = 16;
  localparam int LW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          reset, clkena, flush, data_valid;
  logic [LW-1:0] cfg_latency;
  logic [W-1:0]  data;
  logic [W-1:0]  q;
  logic          q_valid, primed, lat_err;
  logic [LW-1:0] cur_latency;

  int n_chk  = 0;
  int n_fail = 0;

  vardelayline #(.WIDTH(W), .MAX_LATENCY(M)) dut (
    .clk(clk), .reset(reset), .clkena(clkena), .cfg_latency(cfg_latency),
    .flush(flush), .data(data), .data_valid(data_valid), .q(q), .q_valid(q_valid),
    .cur_latency(cur_latency), .primed(primed), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every sample accepted since reset, in order, plus the count of samples
  // killed by the most recent discard.  Output at latency L is the sample accepted L enabled edges ago.
  logic [W-1:0]  hist_d[$];
  bit            hist_v[$];
  int            m_disc  = 0;
  int            m_lat   = 0;
  bit            m_err   = 0;
  bit            m_ready = 0;

  function automatic int clampl(input logic [LW-1:0] c);
    return (int'(c) > M) ? M : int'(c);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist_d.delete();
      hist_v.delete();
      m_disc  = 0;
      m_lat   = clampl(cfg_latency);
      m_err   = 0;
      m_ready = 1;
    end else if (clkena) begin
      hist_d.push_back(data);
      hist_v.push_back(data_valid);
      if (flush || int'(cfg_latency) != m_lat) m_disc = hist_d.size();
      if (int'(cfg_latency) != m_lat) begin
        if (int'(cfg_latency) > M) m_err = 1;
        m_lat = clampl(cfg_latency);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      int n, idx, fill;
      logic [W-1:0] eq;
      logic ev, ep;
      n = hist_d.size();
      eq = '0;
      ev = 1'b0;
      if (m_lat == 0) begin
        eq = data;
        ev = data_valid;
      end else if (n >= m_lat) begin
        idx = n - m_lat;
        eq  = hist_d[idx];
        ev  = hist_v[idx] && (idx >= m_disc);
      end
      fill = (n - m_disc > M) ? M : n - m_disc;
      ep   = (m_lat == 0) || (fill >= m_lat);
      chk("model_q", q, eq);
      chk("model_q_valid", q_valid, ev);
      chk("model_cur_latency", cur_latency, m_lat);
      chk("model_primed", primed, ep);
      chk("model_lat_err", lat_err, m_err);
    end
  end

  task automatic setin(input logic rst, input logic en, input logic [LW-1:0] cfg,
                       input logic fl, input logic [W-1:0] d, input logic dv);
    reset = rst; clkena = en; cfg_latency = cfg; flush = fl; data = d; data_valid = dv;
  endtask

  task automatic go(input logic rst, input logic en, input logic [LW-1:0] cfg,
                    input logic fl, input logic [W-1:0] d, input logic dv);
    setin(rst, en, cfg, fl, d, dv);
    #1;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] dd, dsave;

  initial begin
    setin(1'b1, 1'b1, 5'd3, 1'b0, 8'h00, 1'b0);
    nx();

    // Latency 3 stream starting right after reset
    for (int c = 0; c < 6; c++) begin
      go(1'b0, 1'b1, 5'd3, 1'b0, 8'(c + 1), 1'b1);
      if (c == 0) begin
        chk("rst_cur_latency", cur_latency, 3);
        chk("rst_q", q, 0);
        chk("rst_primed", primed, 0);
        chk("rst_lat_err", lat_err, 0);
      end
      if (c < 3) chk("lat3_q_valid_low", q_valid, 0);
      if (c == 2) chk("lat3_primed_low", primed, 0);
      if (c == 3) begin
        chk("lat3_first_q", q, 1);
        chk("lat3_first_q_valid", q_valid, 1);
        chk("lat3_primed_high", primed, 1);
      end
      if (c == 4) chk("lat3_second_q", q, 2);
      nx();
    end

    // Zero latency passes the input straight through
    go(1'b0, 1'b1, 5'd0, 1'b0, 8'h5A, 1'b1);
    nx();
    go(1'b0, 1'b1, 5'd0, 1'b0, 8'h5A, 1'b1);
    chk("lat0_q", q, 8'h5A);
    chk("lat0_q_valid", q_valid, 1);
    chk("lat0_primed", primed, 1);
    chk("lat0_cur", cur_latency, 0);
    nx();
    go(1'b0, 1'b1, 5'd0, 1'b0, 8'h33, 1'b0);
    chk("lat0_q_invalid", q_valid, 0);
    nx();

    // Latency 4 stream with a 5-cycle clkena hold
    dd = 8'h10;
    for (int i = 0; i < 21; i++) begin
      logic en;
      en = !(i >= 8 && i < 13);
      go(1'b0, en, 5'd4, 1'b0, en ? dd : 8'hEE, 1'b1);
      if (i == 4) chk("lat4_q_valid_low", q_valid, 0);
      if (i == 5) begin
        chk("lat4_first_q", q, 8'h11);
        chk("lat4_first_q_valid", q_valid, 1);
        chk("lat4_primed", primed, 1);
      end
      if (i >= 8 && i <= 13) begin
        chk("hold_q", q, 8'h14);
        chk("hold_q_valid", q_valid, 1);
      end
      if (i == 14) chk("resume_q", q, 8'h15);
      if (en) dd++;
      nx();
    end

    // Latency 4 -> 2 mid-stream
    dsave = '0;
    for (int j = 0; j < 8; j++) begin
      go(1'b0, 1'b1, (j >= 2) ? 5'd2 : 5'd4, 1'b0, dd, 1'b1);
      if (j == 3) begin
        dsave = dd;
        chk("chg_primed_low", primed, 0);
      end
      if (j == 3 || j == 4) begin
        chk("chg_q_valid_low", q_valid, 0);
        chk("chg_cur", cur_latency, 2);
      end
      if (j == 5) begin
        chk("chg_first_q", q, dsave);
        chk("chg_first_q_valid", q_valid, 1);
      end
      dd++;
      nx();
    end

    // Out-of-range request, then back in range; lat_err sticks until reset
    for (int k = 0; k < 12; k++) begin
      go(1'b0, 1'b1, (k < 3) ? 5'd20 : 5'd5, 1'b0, dd, 1'b1);
      if (k == 1 || k == 2) begin
        chk("oor_cur", cur_latency, 16);
        chk("oor_lat_err", lat_err, 1);
        chk("oor_q_valid", q_valid, 0);
        chk("oor_primed", primed, 0);
      end
      if (k == 4) begin
        chk("back_cur", cur_latency, 5);
        chk("back_lat_err", lat_err, 1);
      end
      if (k == 8) chk("back_q_valid_low", q_valid, 0);
      if (k == 10) begin
        chk("back_q_valid", q_valid, 1);
        chk("back_lat_err_still", lat_err, 1);
      end
      dd++;
      nx();
    end
    go(1'b1, 1'b0, 5'd5, 1'b0, dd, 1'b1);
    nx();
    go(1'b0, 1'b1, 5'd5, 1'b0, dd, 1'b1);
    chk("rst_clears_lat_err", lat_err, 0);
    chk("rst_dis_q", q, 0);
    chk("rst_dis_q_valid", q_valid, 0);
    chk("rst_dis_cur", cur_latency, 5);
    nx();

    // Flush at latency 6, then a mid-stream reset
    dsave = '0;
    for (int f = 0; f < 22; f++) begin
      go(1'b0, 1'b1, 5'd6, (f == 10), dd, 1'b1);
      if (f == 10) begin
        chk("pre_flush_q_valid", q_valid, 1);
        chk("pre_flush_primed", primed, 1);
      end
      if (f == 11) dsave = dd;
      if (f >= 11 && f <= 16) begin
        chk("flush_q_valid_low", q_valid, 0);
        chk("flush_primed_low", primed, 0);
      end
      if (f == 17) begin
        chk("flush_first_q", q, dsave);
        chk("flush_first_q_valid", q_valid, 1);
        chk("flush_primed_high", primed, 1);
      end
      dd++;
      nx();
    end
    go(1'b1, 1'b1, 5'd6, 1'b0, dd, 1'b1);
    nx();
    go(1'b0, 1'b1, 5'd6, 1'b0, dd, 1'b1);
    chk("midrst_q", q, 0);
    chk("midrst_q_valid", q_valid, 0);
    chk("midrst_primed", primed, 0);
    nx();
    for (int p = 0; p < 10; p++) begin
      go(1'b0, 1'b1, 5'd6, 1'b0, dd, (p % 2) == 0);
      dd++;
      nx();
    end

    // Latency 16 and 1 with valid gaps, flush-with-change, and a flush ignored while disabled
    for (int g = 0; g < 42; g++) begin
      go(1'b0, (g != 25), (g < 30) ? 5'd16 : 5'd1, (g == 20 || g == 25 || g == 30),
         dd, (g % 3) != 0);
      if (g == 29) chk("max_lat_no_err", lat_err, 0);
      if (g == 31) chk("lat1_cur", cur_latency, 1);
      dd++;
      nx();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
